// File: rtl/mem_vec_drain.sv
// Snapshots a per-memory request vector and grants each set bit once, round-robin, over valid/ready.
// Build option MEM_VEC_DRAIN_MERGE_EN: loads arriving while a batch is held are merged instead of dropped.
module mem_vec_drain #(
  parameter  int NUM_MEM = 6,
  localparam int IDX_W   = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_MEM-1:0] x_in,
  input  logic               x_load,
  output logic               busy,
  output logic               idx_valid,
  output logic [IDX_W-1:0]   idx,
  input  logic               idx_ready,
  output logic               done,
  output logic               load_drop
);

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DONE} state_e;

  state_e             state_q;
  logic [NUM_MEM-1:0] pend_q, pend_d, clr_mask;
  logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_load, idx_next;
  logic               busy_q, idx_valid_q, done_q, load_drop_q;
  logic               hs;

  // First set bit of vec at or above start, wrapping NUM_MEM-1 -> 0.
  function automatic logic [IDX_W-1:0] first_set(input logic [NUM_MEM-1:0] vec,
                                                 input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] res;
    logic             found;
    int               pos;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MEM; k++) begin
      pos = (int'(start) + k) % NUM_MEM;
      if (!found && vec[pos]) begin
        res   = IDX_W'(pos);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    hs       = idx_valid_q & idx_ready;
    clr_mask = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      clr_mask[i] = hs && (idx_q == IDX_W'(i));
    end
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = (idx_q == IDX_W'(NUM_MEM - 1)) ? '0 : idx_q + 1'b1;
    end
    pend_d = pend_q & ~clr_mask;
`ifdef MEM_VEC_DRAIN_MERGE_EN
    // A bit granted this cycle is re-armed if the incoming vector has it set.
    if (x_load) begin
      pend_d = pend_d | x_in;
    end
`endif
    idx_next = first_set(pend_d, ptr_d);
    idx_load = first_set(x_in, ptr_q);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_drop_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      load_drop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (x_load && x_in != '0) begin
            pend_q      <= x_in;
            idx_q       <= idx_load;
            idx_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_EMIT;
          end else if (x_load) begin
            done_q <= 1'b1;
          end
        end

        ST_EMIT: begin
`ifndef MEM_VEC_DRAIN_MERGE_EN
          if (x_load) begin
            load_drop_q <= 1'b1;
          end
`endif
          pend_q <= pend_d;
          if (hs) begin
            ptr_q <= ptr_d;
            if (pend_d != '0) begin
              idx_q <= idx_next;
            end else begin
              idx_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
`ifdef MEM_VEC_DRAIN_MERGE_EN
          if (x_load && x_in != '0) begin
            pend_q      <= x_in;
            idx_q       <= idx_load;
            idx_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_EMIT;
          end else if (x_load) begin
            done_q <= 1'b1;
          end
`else
          if (x_load) begin
            load_drop_q <= 1'b1;
          end
`endif
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign idx_valid = idx_valid_q;
  assign idx       = idx_q;
  assign done      = done_q;
  assign load_drop = load_drop_q;

endmodule

// File: tb/tb_mem_vec_drain.sv
// Self-checking bench for mem_vec_drain: directed scenarios plus randomized batches against
// a set/rotation reference model of the expected grant order.
module tb_mem_vec_drain;

  localparam int N = 6;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] x_in;
  logic         x_load;
  logic         busy, idx_valid, idx_ready, done, load_drop;
  logic [W-1:0] idx;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  mem_vec_drain #(.NUM_MEM(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .x_load    (x_load),
    .busy      (busy),
    .idx_valid (idx_valid),
    .idx       (idx),
    .idx_ready (idx_ready),
    .done      (done),
    .load_drop (load_drop)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected grant order: the set members of vec listed cyclically starting at start.
  task automatic build_order(input logic [N-1:0] vec, input int start);
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      int p;
      p = (start + k) % N;
      if (vec[p]) exp_q.push_back(p);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; x_load = 1'b0; x_in = '0; idx_ready = 1'b0;
    step();
    step();
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  // mode: 0 = ready always high, 1 = random ready, 2 = ready low for the first 3 cycles.
  // inj != 0: load inj alongside the first grant of the batch.
  task automatic run_batch(input logic [N-1:0] vec, input int mode, input logic [N-1:0] inj);
    int           cyc;
    int           last;
    logic         rdy;
    logic [N-1:0] rest;
    bit           injected;
    build_order(vec, m_ptr);
    x_in = vec; x_load = 1'b1;
    step();
    x_load = 1'b0; x_in = '0;
    if (vec == '0) begin
      check("zero_done", done, 1);
      check("zero_valid", idx_valid, 0);
      check("zero_busy", busy, 0);
      step();
      check("zero_done_end", done, 0);
      check("zero_valid_end", idx_valid, 0);
      return;
    end
    cyc = 0; last = 0; injected = 0;
    while (exp_q.size() > 0 && cyc < 300) begin
      check("valid", idx_valid, 1);
      check("busy", busy, 1);
      check("done_mid", done, 0);
      check("idx", idx, exp_q[0]);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc >= 3);
      endcase
      if (inj != '0 && !injected) begin
        rdy = 1'b1; x_load = 1'b1; x_in = inj;
      end
      idx_ready = rdy;
      step();
      cyc++;
      x_load = 1'b0; x_in = '0;
      if (rdy) begin
        last  = exp_q.pop_front();
        m_ptr = (last + 1) % N;
      end
      if (inj != '0 && !injected) begin
        injected = 1;
`ifdef MEM_VEC_DRAIN_MERGE_EN
        rest = inj;
        foreach (exp_q[i]) rest[exp_q[i]] = 1'b1;
        build_order(rest, m_ptr);
        check("merge_no_drop", load_drop, 0);
`else
        rest = '0;
        check("load_drop", load_drop, 1);
`endif
      end
    end
    if (cyc >= 300) check("drain_budget", cyc, 0);
    idx_ready = 1'b0;
    check("end_valid", idx_valid, 0);
    check("end_done", done, 1);
    check("end_busy", busy, 1);
    check("end_idx_held", idx, last);
    if (inj == '0) check("end_no_drop", load_drop, 0);
    step();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_idx_held", idx, last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut();
    check("rst_busy", busy, 0);
    check("rst_valid", idx_valid, 0);
    check("rst_idx", idx, 0);
    check("rst_done", done, 0);
    check("rst_drop", load_drop, 0);

    // Basic batch, then two batches showing the pointer carrying over.
    run_batch(6'b100101, 0, '0);
    run_batch(6'b001100, 0, '0);
    run_batch(6'b010011, 0, '0);

    // Backpressure from a fresh pointer.
    reset_dut();
    run_batch(6'b000110, 2, '0);

    // Empty load.
    run_batch(6'b000000, 0, '0);

    // Load while a batch is held.
    reset_dut();
    run_batch(6'b000011, 0, 6'b100000);

    // Reset in the middle of a drain.
    reset_dut();
    x_in = 6'b111111; x_load = 1'b1; idx_ready = 1'b1;
    step();
    x_load = 1'b0; x_in = '0;
    check("mid_idx0", idx, 0);
    step();
    check("mid_idx1", idx, 1);
    step();
    check("mid_idx2", idx, 2);
    rst = 1'b1; idx_ready = 1'b0;
    step();
    rst = 1'b0; m_ptr = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", idx_valid, 0);
    check("mid_rst_idx", idx, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_drop", load_drop, 0);
    run_batch(6'b000100, 0, '0);

    // Randomized batches with random backpressure.
    for (int b = 0; b < 40; b++) begin
      run_batch(N'($urandom_range(0, (1 << N) - 1)), (b % 4 == 0) ? 0 : 1, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
